// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX serializer among NUM_REQ byte sources.
// Build option UART_TX_ARB_PRIO0_EN: requester 0 wins whenever it is requesting.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 1914
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [2:0]           o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int          IW       = $clog2(NUM_REQ);
    localparam logic [2:0]  PTR_RST  = 3'(NUM_REQ - 1);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CLKS - 1);
    localparam bit          WD_EN    = (TIMEOUT_CLKS != 0);

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;

    logic          win_vld;
    logic [2:0]    win_id;
    logic [7:0]    win_byte;
    logic [IW-1:0] idx;

    // Search starts just after the last winner, so it has lowest priority.
    always_comb begin : pick
        win_vld  = 1'b0;
        win_id   = grant_q;
        win_byte = 8'h00;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(grant_q) + i) % NUM_REQ);
            if (!win_vld && i_Req_DV[idx]) begin
                win_vld  = 1'b1;
                win_id   = 3'(idx);
                win_byte = i_Req_Byte[{idx, 3'b000} +: 8];
            end
        end
`ifdef UART_TX_ARB_PRIO0_EN
        if (i_Req_DV[0]) begin
            win_vld  = 1'b1;
            win_id   = 3'd0;
            win_byte = i_Req_Byte[7:0];
        end
`endif
    end

    always_comb begin : fsm
        state_d   = state_q;
        grant_d   = grant_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        o_Tx_DV   = 1'b0;
        o_Req_Ack = '0;
        o_Timeout = 1'b0;
        o_Busy    = 1'b1;
        case (state_q)
            IDLE: begin
                o_Busy = 1'b0;
                if (win_vld && !i_Tx_Active) begin
                    grant_d = win_id;
                    byte_d  = win_byte;
                    state_d = SEND;
                end
            end
            SEND: begin
                o_Tx_DV   = 1'b1;
                o_Req_Ack = NUM_REQ'(1) << grant_q;
                cnt_d     = '0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done pulse on the expiry cycle still counts as a clean finish.
                if (i_Tx_Done) begin
                    state_d = IDLE;
                end else if (WD_EN && cnt_q == CNT_LAST) begin
                    o_Timeout = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            grant_q <= PTR_RST;
            byte_q  <= 8'h00;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Tx_Byte  = byte_q;
    assign o_Grant_Id = grant_q;

endmodule
